// File: rtl/fpadd_pkg.sv
// Shared state encoding and IEEE-754 single-precision field helpers for the
// fpadd issue sequencer and its special-operand classifier.
package fpadd_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int CNT_W = 4;

    localparam logic [FP_W-1:0]  FP_QNAN      = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fsm_state_e;

    function automatic logic is_nan(input logic [FP_W-1:0] x);
        return (x[FP_W-2 -: EXP_W] == EXP_ALL_ONES) && (x[MAN_W-1:0] != {MAN_W{1'b0}});
    endfunction

    function automatic logic is_inf(input logic [FP_W-1:0] x);
        return (x[FP_W-2 -: EXP_W] == EXP_ALL_ONES) && (x[MAN_W-1:0] == {MAN_W{1'b0}});
    endfunction

    function automatic logic is_zero(input logic [FP_W-1:0] x);
        return x[FP_W-2:0] == {(FP_W-1){1'b0}};
    endfunction

endpackage

// File: rtl/fpadd_issue_ctrl_special.sv
// Combinational classifier for operand pairs whose sum is fixed by IEEE-754
// special-value rules (NaN, infinity, signed zero); used only by the bypass build.
module fp_special_detect
    import fpadd_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         special,
    output logic [W-1:0] special_res
);

    // Priority: NaN beats infinity, opposing infinities make a NaN, then zeros.
    always_comb begin
        special     = 1'b0;
        special_res = {W{1'b0}};
        if (is_nan(a) || is_nan(b)) begin
            special     = 1'b1;
            special_res = FP_QNAN;
        end else if (is_inf(a) && is_inf(b)) begin
            special     = 1'b1;
            special_res = (a[W-1] != b[W-1]) ? FP_QNAN : a;
        end else if (is_inf(a)) begin
            special     = 1'b1;
            special_res = a;
        end else if (is_inf(b)) begin
            special     = 1'b1;
            special_res = b;
        end else if (is_zero(a) && is_zero(b)) begin
            special     = 1'b1;
            special_res = {a[W-1] & b[W-1], {(W-1){1'b0}}};
        end else begin
            special     = 1'b0;
            special_res = {W{1'b0}};
        end
    end

endmodule

// File: rtl/fpadd_issue_ctrl.sv
// Streams operand pairs through the fixed-latency fpadd_single, one in flight.
// Optional special-operand bypass is enabled by defining FPADD_SPECIAL_BYPASS_EN.
module fpadd_issue_ctrl
    import fpadd_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         busy
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("fpadd_issue_ctrl: LATENCY must be within 1..15");
        end
    endgenerate

    fsm_state_e       state_r;
    fsm_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] load_cnt_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             finish_s;
    logic             release_s;
    logic             special_s;
    logic [W-1:0]     special_res_s;
    logic             byp_pend_r;
    logic [W-1:0]     add_a_r;
    logic [W-1:0]     add_b_r;
    logic [W-1:0]     res_data_r;
    logic             res_valid_r;
    logic             busy_r;

`ifdef FPADD_SPECIAL_BYPASS_EN
    fp_special_detect #(
        .W (W)
    ) u_special (
        .a           (in_a),
        .b           (in_b),
        .special     (special_s),
        .special_res (special_res_s)
    );
`else
    assign special_s     = 1'b0;
    assign special_res_s = {W{1'b0}};
`endif

    // A bypassed pair already has its answer; one pass through WAIT gives it a single-cycle latency.
    assign load_cnt_s = special_s ? {CNT_W{1'b0}} : LAT_C;

    // Next-state, counter and handshake decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        in_ready_s  = 1'b0;
        accept_s    = 1'b0;
        finish_s    = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = load_cnt_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    finish_s    = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_HOLD: begin
                in_ready_s = res_ready;
                if (res_ready) begin
                    release_s = 1'b1;
                    if (in_valid) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = load_cnt_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Operand, result and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_a_r     <= {W{1'b0}};
            add_b_r     <= {W{1'b0}};
            byp_pend_r  <= 1'b0;
            res_data_r  <= {W{1'b0}};
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            if (accept_s) begin
                add_a_r    <= in_a;
                add_b_r    <= in_b;
                byp_pend_r <= special_s;
            end
            // Accept and finish are mutually exclusive, so the two loads never collide.
            if (finish_s && !byp_pend_r) begin
                res_data_r <= add_out;
            end else if (accept_s && special_s) begin
                res_data_r <= special_res_s;
            end
            if (finish_s) begin
                res_valid_r <= 1'b1;
            end else if (release_s) begin
                res_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign res_data  = res_data_r;
    assign res_valid = res_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Scoreboard bench for fpadd_issue_ctrl with a behavioural fixed-latency adder stand-in.
module tb_fpadd_issue_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lat;
    } item_t;
    item_t q[$];
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;

    fpadd_issue_ctrl #(.LATENCY(LAT), .W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- small-integer float helpers: exact sums for integer-valued operands ----
    function automatic logic [31:0] int_to_f32(input int unsigned n);
        int p;
        logic [31:0] nn;
        if (n == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 32; i++) if (n[i]) p = i;
        nn = n << (23 - p);
        return {1'b0, 8'(127 + p), nn[22:0]};
    endfunction

    function automatic bit is_small(input logic [31:0] f);
        return (f[31] == 1'b0) && (f[30:23] >= 8'd127) && (f[30:23] <= 8'd149);
    endfunction

    function automatic int unsigned f32_to_int(input logic [31:0] f);
        int p;
        logic [23:0] m;
        p = int'(f[30:23]) - 127;
        m = {1'b1, f[22:0]};
        return int'(m >> (23 - p));
    endfunction

    // Adder stand-in: true sum for small integers, otherwise a distinctive fingerprint.
    function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
        if (is_small(a) && is_small(b)) return int_to_f32(f32_to_int(a) + f32_to_int(b));
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // IEEE-754 special-value sum rules, as the bypass is expected to apply them.
    function automatic logic [32:0] byp_model(input logic [31:0] a, input logic [31:0] b);
        bit an, bn, ai, bi, az, bz;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        az = (a[30:0] == 31'd0);
        bz = (b[30:0] == 31'd0);
        if (an || bn) return {1'b1, 32'h7FC0_0000};
        if (ai && bi) return {1'b1, (a[31] == b[31]) ? a : 32'h7FC0_0000};
        if (ai) return {1'b1, a};
        if (bi) return {1'b1, b};
        if (az && bz) return {1'b1, (a[31] & b[31]) ? 32'h8000_0000 : 32'h0};
        return {1'b0, 32'h0};
    endfunction

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output int l);
        logic [32:0] sp;
        sp = byp_model(a, b);
        d  = stub_sum(a, b);
        l  = LAT + 1;
`ifdef FPADD_SPECIAL_BYPASS_EN
        if (sp[32]) begin
            d = sp[31:0];
            l = 1;
        end
`else
        if (sp[32]) l = LAT + 1;
`endif
    endfunction

    // ---- adder stand-in with LAT register stages ----
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= stub_sum(add_a, add_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_out = pipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // ---- monitor: compares every cycle on the falling edge, then predicts the next edge ----
    always @(negedge clk) begin
        bit          exp_valid;
        bit          exp_rdy;
        logic [31:0] d;
        int          l;
        if (!reset) begin
            q.delete();
            last_a = 32'h0;
            last_b = 32'h0;
            chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_res_data", res_data, 32'h0);
            chk("rst_add_ab", add_a | add_b, 32'h0);
        end else begin
            exp_valid = (q.size() > 0) && (cyc >= q[0].acc + q[0].lat);
            exp_rdy   = (q.size() == 0) || (exp_valid && res_ready);
            chk("res_valid", {31'd0, res_valid}, {31'd0, exp_valid});
            if (exp_valid) chk("res_data", res_data, q[0].data);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            chk("add_a", add_a, last_a);
            chk("add_b", add_b, last_b);
            if (exp_valid && res_ready) void'(q.pop_front());
            if (exp_rdy && in_valid) begin
                model(in_a, in_b, d, l);
                q.push_back('{data: d, acc: cyc + 1, lat: l});
                last_a = in_a;
                last_b = in_b;
            end
        end
    end

    // ---- stimulus helpers ----
    task automatic send(input logic [31:0] a, input logic [31:0] b, output int acc_c);
        int n;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        acc_c = -1;
        n = 0;
        while (acc_c < 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (in_ready && reset) acc_c = cyc + 1;
        end
        if (acc_c < 0) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed %0d, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string nm, input logic [31:0] exp, input int acc_c, input int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 60);
        total++;
        if (!res_valid) begin
            bad++;
            $display("FAIL %s_timeout: res_valid=0, required 1", nm);
        end else begin
            chk({nm, "_data"}, res_data, exp);
            chk({nm, "_latency"}, 32'(cyc - acc_c), 32'(lat));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_int_op();
        return int_to_f32($urandom_range(1, 1000));
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: v = 32'h7F80_0000;
            1: v = 32'hFF80_0000;
            2: v = 32'h7FC0_0001;
            3: v = 32'h0000_0000;
            4: v = 32'h8000_0000;
            default: v = rand_int_op();
        endcase
        return v;
    endfunction

    int  acc, acc2, prev_acc, rr_edge;
    bit  rnd_done;

    initial begin
        in_valid  = 1'b0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        res_ready = 1'b1;
        reset     = 1'b1;
        #2 reset  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // basic add: 1.0 + 2.0
        send(32'h3F80_0000, 32'h4000_0000, acc);
        expect_result("basic", 32'h4040_0000, acc, LAT + 1);

        // backpressure: result held while a second pair waits for the release edge
        res_ready = 1'b0;
        send(32'h40A0_0000, 32'h3F80_0000, acc);
        expect_result("bp", 32'h40C0_0000, acc, LAT + 1);
        fork
            send(32'h4000_0000, 32'h4000_0000, acc2);
            begin
                repeat (5) @(posedge clk);
                #1 res_ready = 1'b1;
                rr_edge = cyc + 1;
            end
        join
        chk("bp_accept_edge", 32'(acc2), 32'(rr_edge));
        expect_result("bp2", 32'h4080_0000, acc2, LAT + 1);

        // back-to-back stream
        for (int i = 0; i < 10; i++) begin
            send(rand_int_op(), rand_int_op(), acc);
            if (i > 0) chk("b2b_period", 32'(acc - prev_acc), 32'(LAT + 2));
            prev_acc = acc;
        end
        drain();

        // reset one cycle after an accept: the sum must vanish
        send(32'h3F80_0000, 32'h3F80_0000, acc);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(32'h3F80_0000, 32'h4000_0000, acc);
        expect_result("after_rst", 32'h4040_0000, acc, LAT + 1);

        // special operand pairs
        send(32'h7F80_0000, 32'hFF80_0000, acc);
`ifdef FPADD_SPECIAL_BYPASS_EN
        expect_result("byp_inf", 32'h7FC0_0000, acc, 1);
`else
        expect_result("nobyp_inf", stub_sum(32'h7F80_0000, 32'hFF80_0000), acc, LAT + 1);
`endif
        send(32'h8000_0000, 32'h8000_0000, acc);
`ifdef FPADD_SPECIAL_BYPASS_EN
        expect_result("byp_negzero", 32'h8000_0000, acc, 1);
`else
        expect_result("nobyp_negzero", stub_sum(32'h8000_0000, 32'h8000_0000), acc, LAT + 1);
`endif

        // randomized traffic with random gaps and random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rand_op(), rand_op(), acc);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 res_ready = ($urandom_range(0, 3) != 0);
                end
                res_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
